mips16_decode_stage: RTL and testbench

Pipelined instruction-decode stage for the 16-bit, 4-register MIPS datapath. It accepts instructions from fetch via a valid/ready handshake and drives the register-file read addresses. It captures the read data, bypassing any same-cycle writeback, and presents a registered decoded bundle to execute. It also detects load-use hazards, inserts bubbles, and supports a branch flush.

---
 rtl/mips16_pkg.sv | 43 ++++
 rtl/mips16_decode_stage_if.sv | 42 ++++
 rtl/mips16_decode_stage_ctrl.sv | 41 ++++
 rtl/mips16_decode_stage.sv | 174 +++++++++++++++++
 tb/tb_mips16_decode_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit, 4-register MIPS decode stage:
// opcodes, instruction field positions and the decoded control bundle.
package mips16_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 10;
  localparam int RT_HI  = 9;
  localparam int RT_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = 8;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic branch;
    logic uses_rt;
    logic is_rtype;
  } ctrl_t;

  // Opcodes above BNE are undefined and behave as NOP.
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op <= OP_BNE);
  endfunction

endpackage

// File: rtl/mips16_decode_stage_if.sv
// Fetch, register-file, writeback and execute signals of the decode stage.
// The stage itself uses the slave view; its environment uses the master view.
interface mips16_decode_stage_if #(
  parameter int DW = 16,
  parameter int AW = 2
);
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] rr1;
  logic [AW-1:0] rr2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          wb_regwrite;
  logic [AW-1:0] wb_wr;
  logic [DW-1:0] wb_wd;
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic [3:0]    ex_op;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic [AW-1:0] ex_wr;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_alusrc;
  logic          ex_branch;

  modport master (
    output if_valid, if_instr, rd1, rd2, wb_regwrite, wb_wr, wb_wd, flush, ex_ready,
    input  if_ready, rr1, rr2, ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_wr,
    input  ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_branch
  );

  modport slave (
    input  if_valid, if_instr, rd1, rd2, wb_regwrite, wb_wr, wb_wd, flush, ex_ready,
    output if_ready, rr1, rr2, ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_wr,
    output ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_branch
  );
endinterface

// File: rtl/mips16_decode_stage_ctrl.sv
// Combinational opcode decoder producing the control bundle and the rs-usage flag.
module mips16_ctrl_decode
  import mips16_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl,
  output logic       uses_rs
);

  always_comb begin
    ctrl    = '0;
    uses_rs = is_defined_op(op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        ctrl.regwrite = 1'b1;
        ctrl.uses_rt  = 1'b1;
        ctrl.is_rtype = 1'b1;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.uses_rt  = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch  = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips16_decode_stage.sv
// Decode stage: holds one fetched instruction, reads and bypasses its operands,
// stalls on load-use hazards and registers the decoded bundle for execute.
module mips16_decode_stage
  import mips16_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mips16_decode_stage_if.slave bus
);

  logic [DW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          ex_valid_q, ex_valid_d;
  logic [3:0]    ex_op_q, ex_op_d;
  logic [DW-1:0] ex_a_q, ex_a_d;
  logic [DW-1:0] ex_b_q, ex_b_d;
  logic [DW-1:0] ex_imm_q, ex_imm_d;
  logic [AW-1:0] ex_wr_q, ex_wr_d;
  logic          ex_regwrite_q, ex_regwrite_d;
  logic          ex_memread_q, ex_memread_d;
  logic          ex_memwrite_q, ex_memwrite_d;
  logic          ex_alusrc_q, ex_alusrc_d;
  logic          ex_branch_q, ex_branch_d;

  logic [3:0]     op;
  logic [AW-1:0]  rs, rt, rd, dest;
  logic [IMM_W-1:0] imm8;
  logic [DW-1:0]  opnd_a, opnd_b;
  ctrl_t          ctrl;
  logic           uses_rs, hazard, advance, if_ready_s, accept;

  assign op   = instr_q[OP_HI:OP_LO];
  assign rs   = instr_q[RS_HI:RS_LO];
  assign rt   = instr_q[RT_HI:RT_LO];
  assign rd   = instr_q[RD_HI:RD_LO];
  assign imm8 = instr_q[IMM_HI:IMM_LO];

  mips16_ctrl_decode u_ctrl (
    .op      (op),
    .ctrl    (ctrl),
    .uses_rs (uses_rs)
  );

  // Operand selection, destination choice and the stall/accept handshake.
  always_comb begin
    opnd_a = bus.rd1;
    opnd_b = bus.rd2;
    if (bus.wb_regwrite && (bus.wb_wr == rs) && (rs != '0)) begin
      opnd_a = bus.wb_wd;
    end else begin
      opnd_a = bus.rd1;
    end
    if (bus.wb_regwrite && (bus.wb_wr == rt) && (rt != '0)) begin
      opnd_b = bus.wb_wd;
    end else begin
      opnd_b = bus.rd2;
    end

    if (ctrl.is_rtype) begin
      dest = rd;
    end else if (ctrl.regwrite) begin
      dest = rt;
    end else begin
      dest = '0;
    end

    hazard = ex_valid_q & ex_memread_q & (ex_wr_q != '0) &
             ((uses_rs & (ex_wr_q == rs)) | (ctrl.uses_rt & (ex_wr_q == rt)));
    advance    = valid_q & ~hazard & (~ex_valid_q | bus.ex_ready);
    if_ready_s = reset_n & ~bus.flush & (~valid_q | advance);
    accept     = bus.if_valid & if_ready_s;
  end

  // Next-state for the holding register and the execute bundle; flush overrides all.
  always_comb begin
    instr_d       = instr_q;
    valid_d       = valid_q;
    ex_valid_d    = ex_valid_q;
    ex_op_d       = ex_op_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    ex_imm_d      = ex_imm_q;
    ex_wr_d       = ex_wr_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    ex_memwrite_d = ex_memwrite_q;
    ex_alusrc_d   = ex_alusrc_q;
    ex_branch_d   = ex_branch_q;

    if (bus.flush) begin
      valid_d    = 1'b0;
      ex_valid_d = 1'b0;
    end else begin
      if (accept) begin
        instr_d = bus.if_instr;
        valid_d = 1'b1;
      end else if (advance) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end

      if (advance) begin
        ex_valid_d    = 1'b1;
        ex_op_d       = op;
        ex_a_d        = opnd_a;
        ex_b_d        = opnd_b;
        ex_imm_d      = {{(DW-IMM_W){imm8[IMM_W-1]}}, imm8};
        ex_wr_d       = dest;
        ex_regwrite_d = ctrl.regwrite & (dest != '0);
        ex_memread_d  = ctrl.memread;
        ex_memwrite_d = ctrl.memwrite;
        ex_alusrc_d   = ctrl.alusrc;
        ex_branch_d   = ctrl.branch;
      end else if (bus.ex_ready && ex_valid_q) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = ex_valid_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      instr_q       <= '0;
      valid_q       <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_op_q       <= 4'd0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_imm_q      <= '0;
      ex_wr_q       <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_alusrc_q   <= 1'b0;
      ex_branch_q   <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_imm_q      <= ex_imm_d;
      ex_wr_q       <= ex_wr_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      ex_alusrc_q   <= ex_alusrc_d;
      ex_branch_q   <= ex_branch_d;
    end
  end

  assign bus.if_ready    = if_ready_s;
  assign bus.rr1         = rs;
  assign bus.rr2         = rt;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_op       = ex_op_q;
  assign bus.ex_a        = ex_a_q;
  assign bus.ex_b        = ex_b_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_wr       = ex_wr_q;
  assign bus.ex_regwrite = ex_regwrite_q;
  assign bus.ex_memread  = ex_memread_q;
  assign bus.ex_memwrite = ex_memwrite_q;
  assign bus.ex_alusrc   = ex_alusrc_q;
  assign bus.ex_branch   = ex_branch_q;

endmodule

// File: tb/tb_mips16_decode_stage.sv
// Scoreboard bench for mips16_decode_stage: expected bundles are queued when an
// instruction is accepted and compared when execute takes the bundle.
module tb_mips16_decode_stage;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  mips16_decode_stage_if bus ();

  mips16_decode_stage #(.DW(16), .AW(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [1:0]  wr;
    logic        chk_wr;
    logic [4:0]  ctrl;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] regs [4];
  int          total_cnt = 0;
  int          bad_cnt = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          prev_pop_cyc = 0;
  logic [15:0] last_a, last_b, last_imm;
  logic [4:0]  last_ctrl;
  logic [59:0] snap;

  assign bus.rd1 = regs[bus.rr1];
  assign bus.rd2 = regs[bus.rr2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [1:0] r);
    if (bus.wb_regwrite && bus.wb_wr == r && r != 2'd0) return bus.wb_wd;
    return (r == 2'd0) ? 16'h0000 : regs[r];
  endfunction

  // Expected bundle; ctrl bits are {regwrite, memread, memwrite, alusrc, branch}.
  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    logic [3:0] op;
    logic [1:0] rs, rt, rd;
    op = ins[15:12]; rs = ins[11:10]; rt = ins[9:8]; rd = ins[7:6];
    e.op = op; e.a = rd_model(rs); e.b = rd_model(rt);
    e.imm = {{8{ins[7]}}, ins[7:0]};
    e.wr = 2'd0; e.chk_wr = 1'b1; e.ctrl = 5'b00000;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin e.wr = rd; e.ctrl = {rd != 2'd0, 4'b0000}; end
      4'd5: begin e.wr = rt; e.ctrl = {rt != 2'd0, 4'b1010}; end
      4'd6: begin e.chk_wr = 1'b0; e.ctrl = 5'b00110; end
      4'd7: begin e.wr = rt; e.ctrl = {rt != 2'd0, 4'b0010}; end
      4'd8, 4'd9: begin e.chk_wr = 1'b0; e.ctrl = 5'b00001; end
      default: begin e.chk_wr = 1'b0; e.ctrl = 5'b00000; end
    endcase
    return e;
  endfunction

  function automatic logic [15:0] r_ins(input logic [3:0] op, input logic [1:0] rs,
                                        input logic [1:0] rt, input logic [1:0] rd);
    return {op, rs, rt, rd, 6'b000000};
  endfunction

  function automatic logic [15:0] i_ins(input logic [3:0] op, input logic [1:0] rs,
                                        input logic [1:0] rt, input logic [7:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [59:0] ex_vec();
    return {bus.ex_valid, bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_imm, bus.ex_wr,
            bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_alusrc, bus.ex_branch};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] ins);
    bit done = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = ins;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.if_ready) begin
        sb_q.push_back(model(ins));
        done = 1'b1;
      end
      tick();
    end
    if (!done) check_val("issue_timeout", 64'd0, 64'd1);
    bus.if_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_val("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compare each bundle taken by execute against the scoreboard head.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("ex_op", bus.ex_op, mon_e.op);
        check_val("ex_a", bus.ex_a, mon_e.a);
        check_val("ex_b", bus.ex_b, mon_e.b);
        check_val("ex_imm", bus.ex_imm, mon_e.imm);
        if (mon_e.chk_wr) check_val("ex_wr", bus.ex_wr, mon_e.wr);
        check_val("ex_ctrl", {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                              bus.ex_alusrc, bus.ex_branch}, mon_e.ctrl);
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
        last_a = bus.ex_a; last_b = bus.ex_b; last_imm = bus.ex_imm;
        last_ctrl = {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_alusrc, bus.ex_branch};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    regs[0] = 16'h0000; regs[1] = 16'h0005; regs[2] = 16'h1234; regs[3] = 16'h00A0;
    reset_n = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = r_ins(4'd0, 2'd1, 2'd2, 2'd3);
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;
    bus.wb_regwrite = 1'b0; bus.wb_wr = 2'd0; bus.wb_wd = 16'h0000;

    // Reset held for two edges with fetch offering an instruction.
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_if_ready", bus.if_ready, 1'b0);
    check_val("rst_ex_zero", ex_vec(), 60'd0);
    bus.if_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check_val("rst_if_ready_after", bus.if_ready, 1'b1);
    tick();

    // Back-to-back ALU instructions.
    issue(r_ins(4'd0, 2'd1, 2'd2, 2'd3));
    issue(r_ins(4'd1, 2'd3, 2'd1, 2'd2));
    drain();
    check_val("b2b_consecutive", 64'(last_pop_cyc - prev_pop_cyc), 64'd1);

    // Writeback bypass on rs, with imm8 sign extension.
    bus.wb_regwrite = 1'b1; bus.wb_wr = 2'd1; bus.wb_wd = 16'hBEEF;
    issue(i_ins(4'd7, 2'd1, 2'd2, 8'hFF));
    drain();
    check_val("bypass_a", last_a, 16'hBEEF);
    check_val("imm_sext", last_imm, 16'hFFFF);
    bus.wb_wr = 2'd2;
    issue(r_ins(4'd0, 2'd1, 2'd2, 2'd3));
    drain();
    check_val("bypass_b", last_b, 16'hBEEF);
    bus.wb_wr = 2'd0; bus.wb_wd = 16'hDEAD;
    issue(r_ins(4'd0, 2'd0, 2'd0, 2'd1));
    drain();
    check_val("no_bypass_r0", last_a, 16'h0000);
    bus.wb_regwrite = 1'b0;

    // Write to $0, other opcode classes and an undefined opcode.
    issue(r_ins(4'd0, 2'd1, 2'd2, 2'd0));
    drain();
    check_val("r0_regwrite", last_ctrl[4], 1'b0);
    issue(i_ins(4'd6, 2'd1, 2'd2, 8'h04));
    issue(i_ins(4'd8, 2'd1, 2'd2, 8'h80));
    issue(i_ins(4'd9, 2'd3, 2'd1, 8'h7F));
    issue(16'hC5A3);
    issue(r_ins(4'd4, 2'd2, 2'd3, 2'd1));
    drain();

    // Load-use: one bubble, dependent operand from writeback.
    bus.wb_regwrite = 1'b1; bus.wb_wr = 2'd2; bus.wb_wd = 16'h7777;
    issue(i_ins(4'd5, 2'd1, 2'd2, 8'h00));
    issue(r_ins(4'd0, 2'd2, 2'd1, 2'd3));
    drain();
    check_val("lu_bubble", 64'(last_pop_cyc - prev_pop_cyc), 64'd2);
    check_val("lu_bypass", last_a, 16'h7777);
    bus.wb_regwrite = 1'b0;

    // Load followed by an instruction that does not read the loaded register.
    issue(i_ins(4'd5, 2'd3, 2'd1, 8'h10));
    issue(i_ins(4'd7, 2'd3, 2'd1, 8'h01));
    drain();
    check_val("lu_no_hazard", 64'(last_pop_cyc - prev_pop_cyc), 64'd1);

    // Back-pressure holds the bundle, then flush discards everything in flight.
    bus.ex_ready = 1'b0;
    issue(r_ins(4'd0, 2'd1, 2'd2, 2'd3));
    issue(r_ins(4'd1, 2'd3, 2'd1, 2'd2));
    bus.if_valid = 1'b1;
    bus.if_instr = r_ins(4'd3, 2'd1, 2'd2, 2'd3);
    snap = ex_vec();
    regs[1] = 16'h0F0F;
    check_val("stall_ex_valid", bus.ex_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stall_hold", ex_vec(), snap);
      check_val("stall_if_ready", bus.if_ready, 1'b0);
    end
    bus.flush = 1'b1;
    #1;
    check_val("flush_if_ready", bus.if_ready, 1'b0);
    tick();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    check_val("flush_ex_valid", bus.ex_valid, 1'b0);
    check_val("flush_valid_q", bus.if_ready, 1'b1);
    sb_q.delete();
    regs[1] = 16'h0005;
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("flush_no_accept", bus.ex_valid, 1'b0);
    end

    // Normal operation resumes after the flush.
    issue(r_ins(4'd2, 2'd2, 2'd3, 2'd1));
    drain();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
